// File: rtl/rip_branch_predictor_const.sv
// Shared types and helpers for the rip branch direction predictor.
package rip_branch_predictor_const;

    // Widest counter the saturating helper can handle.
    localparam int unsigned SAT_MAX_W = 16;

    typedef enum logic [0:0] {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    // Saturating +/-1 on a width-bit counter held in the low bits of ctr.
    // Arithmetic is one bit wider than the counter, then clamped.
    function automatic logic [SAT_MAX_W-1:0] sat_update(
        input logic [SAT_MAX_W-1:0] ctr,
        input logic                 taken,
        input int unsigned          width
    );
        logic [SAT_MAX_W:0] wide;
        logic [SAT_MAX_W:0] max_val;
        max_val = (SAT_MAX_W+1)'((33'(1) << width) - 33'(1));
        wide    = {1'b0, ctr};
        if (taken) begin
            wide = wide + (SAT_MAX_W+1)'(1);
            if (wide > max_val) wide = max_val;
        end else begin
            wide = wide - (SAT_MAX_W+1)'(1);
            if (wide[SAT_MAX_W]) wide = '0;
        end
        return wide[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/rip_2r1w_bram.sv
// Counter table storage: port 1 writes, port 2 reads synchronously (old data on collision).
module rip_2r1w_bram #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [ADDR_W-1:0] p2_addr,
    output logic [DATA_W-1:0] p2_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; array contents are established by the init sweep, not by reset.
    always_ff @(posedge clk) begin
        if (p1_we) mem[p1_addr] <= p1_wdata;
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) p2_rdata <= '0;
        else     p2_rdata <= mem[p2_addr];
    end

endmodule

// File: rtl/rip_gshare_predictor_param.sv
// gshare/bimodal direction predictor with init sweep, write->read bypass and
// optional speculative history (enable with macro BP_SPEC_HISTORY_EN).
module rip_gshare_predictor_param
    import rip_branch_predictor_const::*;
#(
    parameter  int unsigned PC_LSB      = 2,
    parameter  int unsigned INDEX_WIDTH = 10,
    parameter  int unsigned HISTORY_LEN = 10,
    parameter  int unsigned CTR_WIDTH   = 2,
    parameter  int unsigned INIT_CTR    = 2 ** (CTR_WIDTH - 1),
    localparam int unsigned HW          = (HISTORY_LEN > 0) ? HISTORY_LEN : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            pc,
    output logic                   ready,
    output logic                   pred_valid,
    output logic [INDEX_WIDTH-1:0] pred_index,
    output logic [CTR_WIDTH-1:0]   pred_ctr,
    output logic                   pred,
    input  logic                   update,
    input  logic [INDEX_WIDTH-1:0] update_index,
    input  logic [CTR_WIDTH-1:0]   update_ctr,
    input  logic                   actual,
    output logic [HW-1:0]          global_history
`ifdef BP_SPEC_HISTORY_EN
    ,
    input  logic                   pred_fire,
    input  logic [HW-1:0]          update_history
`endif
);

    localparam int unsigned DEPTH = 1 << INDEX_WIDTH;

    bp_state_e              state_q, state_d;
    logic [INDEX_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic [HW-1:0]          hist_q, hist_d;
    logic                   wr_en;
    logic [INDEX_WIDTH-1:0] wr_addr;
    logic [CTR_WIDTH-1:0]   wr_data;
    logic [INDEX_WIDTH-1:0] rd_idx;
    logic [CTR_WIDTH-1:0]   rd_data;
    logic                   byp_hit_q;
    logic [CTR_WIDTH-1:0]   byp_data_q;
    logic                   unused_ok;

    assign unused_ok = &{1'b0, pc
`ifdef BP_SPEC_HISTORY_EN
                         , update_history
`endif
                        };

    // Predict index: PC slice folded with the zero-extended global history.
    assign rd_idx = pc[PC_LSB +: INDEX_WIDTH] ^ INDEX_WIDTH'(hist_q);

    rip_2r1w_bram #(
        .ADDR_W (INDEX_WIDTH),
        .DATA_W (CTR_WIDTH)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .p1_we    (wr_en),
        .p1_addr  (wr_addr),
        .p1_wdata (wr_data),
        .p2_addr  (rd_idx),
        .p2_rdata (rd_data)
    );

    // State register for the init sweep / run FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BP_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Next state and table write mux: sweep writes during init, resolved updates during run.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        case (state_q)
            BP_INIT: begin
                wr_en      = 1'b1;
                wr_addr    = init_cnt_q;
                wr_data    = CTR_WIDTH'(INIT_CTR);
                init_cnt_d = init_cnt_q + INDEX_WIDTH'(1);
                if (init_cnt_q == INDEX_WIDTH'(DEPTH - 1)) state_d = BP_RUN;
            end
            BP_RUN: begin
                if (update) begin
                    wr_en   = 1'b1;
                    wr_addr = update_index;
                    wr_data = CTR_WIDTH'(sat_update(SAT_MAX_W'(update_ctr), actual, CTR_WIDTH));
                end
            end
            default: state_d = BP_INIT;
        endcase
    end

    // Next global history; a mispredict restores from the checkpoint carried with the branch.
    always_comb begin
        hist_d = hist_q;
        if (state_q == BP_RUN) begin
`ifdef BP_SPEC_HISTORY_EN
            if (update && (update_ctr[CTR_WIDTH-1] != actual))
                hist_d = HW'({update_history, actual});
            else if (pred_fire)
                hist_d = HW'({hist_q, pred});
`else
            if (update)
                hist_d = HW'({hist_q, actual});
`endif
        end
        if (HISTORY_LEN == 0) hist_d = '0;
    end

    // Registered outputs, history and the bypass capture of a same-index write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready      <= 1'b0;
            pred_valid <= 1'b0;
            pred_index <= '0;
            hist_q     <= '0;
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            ready      <= (state_d == BP_RUN);
            pred_valid <= ready;
            pred_index <= rd_idx;
            hist_q     <= hist_d;
            byp_hit_q  <= wr_en && (wr_addr == rd_idx);
            byp_data_q <= wr_data;
        end
    end

    assign pred_ctr       = byp_hit_q ? byp_data_q : rd_data;
    assign pred           = pred_ctr[CTR_WIDTH-1];
    assign global_history = hist_q;

endmodule

// File: tb/tb_rip_gshare_predictor_param.sv
// Self-checking bench for rip_gshare_predictor_param (gshare DUT plus a bimodal DUT).
module tb_rip_gshare_predictor_param;

    localparam int unsigned IW = 4;
    localparam int unsigned CW = 2;
    localparam int unsigned HL = 4;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [CW-1:0] ctr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // gshare DUT
    logic [31:0]   pc;
    logic          update;
    logic [IW-1:0] update_index;
    logic [CW-1:0] update_ctr;
    logic          actual;
    logic          ready, pred_valid, pred;
    logic [IW-1:0] pred_index;
    logic [CW-1:0] pred_ctr;
    logic [HL-1:0] global_history;
`ifdef BP_SPEC_HISTORY_EN
    logic          pred_fire;
    logic [HL-1:0] update_history;
    logic          pred_fire_b;
    logic [0:0]    update_history_b;
`endif

    // bimodal DUT (HISTORY_LEN = 0)
    logic [31:0]   pc_b;
    logic          update_b;
    logic [IW-1:0] update_index_b;
    logic [CW-1:0] update_ctr_b;
    logic          actual_b;
    logic          ready_b, pred_valid_b, pred_b;
    logic [IW-1:0] pred_index_b;
    logic [CW-1:0] pred_ctr_b;
    logic [0:0]    global_history_b;

    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];
    logic [CW-1:0] mem_m [16];
    logic [HL-1:0] hist_m;

    rip_gshare_predictor_param #(
        .PC_LSB(2), .INDEX_WIDTH(IW), .HISTORY_LEN(HL), .CTR_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .pc(pc), .ready(ready), .pred_valid(pred_valid),
        .pred_index(pred_index), .pred_ctr(pred_ctr), .pred(pred),
        .update(update), .update_index(update_index), .update_ctr(update_ctr),
        .actual(actual), .global_history(global_history)
`ifdef BP_SPEC_HISTORY_EN
        , .pred_fire(pred_fire), .update_history(update_history)
`endif
    );

    rip_gshare_predictor_param #(
        .PC_LSB(2), .INDEX_WIDTH(IW), .HISTORY_LEN(0), .CTR_WIDTH(CW)
    ) dut_b (
        .clk(clk), .rst(rst), .pc(pc_b), .ready(ready_b), .pred_valid(pred_valid_b),
        .pred_index(pred_index_b), .pred_ctr(pred_ctr_b), .pred(pred_b),
        .update(update_b), .update_index(update_index_b), .update_ctr(update_ctr_b),
        .actual(actual_b), .global_history(global_history_b)
`ifdef BP_SPEC_HISTORY_EN
        , .pred_fire(pred_fire_b), .update_history(update_history_b)
`endif
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [CW-1:0] m_sat(input logic [CW-1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        else   return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    task automatic idle_inputs();
        pc = '0; update = 1'b0; update_index = '0; update_ctr = '0; actual = 1'b0;
        pc_b = '0; update_b = 1'b0; update_index_b = '0; update_ctr_b = '0; actual_b = 1'b0;
`ifdef BP_SPEC_HISTORY_EN
        pred_fire = 1'b0; update_history = '0; pred_fire_b = 1'b0; update_history_b = '0;
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem_m[i] = 2'd2;
        hist_m = '0;
        sb_q.delete();
    endtask

    // Full reset and sweep; an expired wait counts as a failed comparison.
    task automatic reset_dut();
        int c;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        c = 0;
        while (ready !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_timeout: ready=%b after %0d cycles, need 1", ready, c);
        end
    endtask

    // One resolved branch on the gshare DUT, with the model following along.
    task automatic do_update(input logic [IW-1:0] idx, input logic a);
        update = 1'b1; update_index = idx; update_ctr = mem_m[idx]; actual = a;
`ifdef BP_SPEC_HISTORY_EN
        update_history = hist_m;
        if (mem_m[idx][CW-1] != a) hist_m = {hist_m[HL-2:0], a};
`else
        hist_m = {hist_m[HL-2:0], a};
`endif
        mem_m[idx] = m_sat(mem_m[idx], a);
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic test_reset();
        int c;
        exp_t e;
        logic [IW-1:0] idxs [4];
        idxs = '{4'd12, 4'd0, 4'd15, 4'd5};
        idle_inputs();
        rst = 1'b1;
        #1;
        n_tests += 7;
        if (ready !== 1'b0)          begin n_fail++; $display("FAIL rst_ready: got %b need 0", ready); end
        if (pred_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_pred_valid: got %b need 0", pred_valid); end
        if (pred_index !== '0)       begin n_fail++; $display("FAIL rst_pred_index: got %h need 0", pred_index); end
        if (pred_ctr !== '0)         begin n_fail++; $display("FAIL rst_pred_ctr: got %h need 0", pred_ctr); end
        if (pred !== 1'b0)           begin n_fail++; $display("FAIL rst_pred: got %b need 0", pred); end
        if (global_history !== '0)   begin n_fail++; $display("FAIL rst_history: got %b need 0", global_history); end
        if (ready_b !== 1'b0)        begin n_fail++; $display("FAIL rst_ready_b: got %b need 0", ready_b); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        c = 0;
        while (ready !== 1'b1 && c < 100) begin
            c++;
            @(negedge clk);
        end
        n_tests++;
        if (c != 16) begin n_fail++; $display("FAIL init_low_cycles: got %0d need 16", c); end
        foreach (idxs[k]) begin
            pc = 32'({idxs[k] ^ hist_m, 2'b00});
            sb_q.push_back('{idx: idxs[k], ctr: mem_m[idxs[k]]});
            @(negedge clk);
            e = sb_q.pop_front();
            n_tests += 4;
            if (pred_index !== e.idx)     begin n_fail++; $display("FAIL init_pred_index: got %h need %h", pred_index, e.idx); end
            if (pred_ctr !== e.ctr)       begin n_fail++; $display("FAIL init_pred_ctr: got %h need %h", pred_ctr, e.ctr); end
            if (pred !== e.ctr[CW-1])     begin n_fail++; $display("FAIL init_pred: got %b need %b", pred, e.ctr[CW-1]); end
            if (pred_valid !== 1'b1)      begin n_fail++; $display("FAIL init_pred_valid: got %b need 1", pred_valid); end
        end
    endtask

    task automatic test_counters();
        exp_t e;
        logic dirs [7];
        dirs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        reset_dut();
        foreach (dirs[k]) begin
            do_update(4'd5, dirs[k]);
            pc = 32'({4'd5 ^ hist_m, 2'b00});
            sb_q.push_back('{idx: 4'd5, ctr: mem_m[5]});
            @(negedge clk);
            e = sb_q.pop_front();
            n_tests += 2;
            if (pred_index !== e.idx) begin n_fail++; $display("FAIL sat_index step%0d: got %h need %h", k, pred_index, e.idx); end
            if (pred_ctr !== e.ctr)   begin n_fail++; $display("FAIL sat_ctr step%0d: got %h need %h", k, pred_ctr, e.ctr); end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        reset_dut();
        update_b = 1'b1; update_index_b = 4'd5; update_ctr_b = 2'd2; actual_b = 1'b1;
        pc_b = 32'h14;
        sb_q.push_back('{idx: 4'd5, ctr: 2'd3});
        @(negedge clk);
        update_b = 1'b0;
        e = sb_q.pop_front();
        n_tests += 4;
        if (pred_index_b !== e.idx)   begin n_fail++; $display("FAIL bypass_index: got %h need %h", pred_index_b, e.idx); end
        if (pred_ctr_b !== e.ctr)     begin n_fail++; $display("FAIL bypass_ctr: got %h need %h", pred_ctr_b, e.ctr); end
        if (pred_b !== 1'b1)          begin n_fail++; $display("FAIL bypass_pred: got %b need 1", pred_b); end
        if (global_history_b !== 1'b0) begin n_fail++; $display("FAIL bimodal_history: got %b need 0", global_history_b); end
        sb_q.push_back('{idx: 4'd5, ctr: 2'd3});
        @(negedge clk);
        e = sb_q.pop_front();
        n_tests++;
        if (pred_ctr_b !== e.ctr) begin n_fail++; $display("FAIL bypass_stored_ctr: got %h need %h", pred_ctr_b, e.ctr); end
    endtask

`ifndef BP_SPEC_HISTORY_EN
    task automatic test_history();
        exp_t e;
        reset_dut();
        do_update(4'd0, 1'b1);
        do_update(4'd0, 1'b0);
        do_update(4'd0, 1'b1);
        do_update(4'd0, 1'b1);
        n_tests++;
        if (global_history !== 4'b1011) begin n_fail++; $display("FAIL history_shift: got %b need 1011", global_history); end
        pc = 32'h14;
        sb_q.push_back('{idx: 4'd14, ctr: mem_m[14]});
        @(negedge clk);
        e = sb_q.pop_front();
        n_tests += 2;
        if (pred_index !== e.idx) begin n_fail++; $display("FAIL history_index: got %h need %h", pred_index, e.idx); end
        if (pred_ctr !== e.ctr)   begin n_fail++; $display("FAIL history_ctr: got %h need %h", pred_ctr, e.ctr); end
        update = 1'b0;
        @(negedge clk);
        n_tests++;
        if (global_history !== 4'b1011) begin n_fail++; $display("FAIL history_hold: got %b need 1011", global_history); end
    endtask
`else
    task automatic test_spec_history();
        reset_dut();
        n_tests++;
        if (pred !== 1'b1) begin n_fail++; $display("FAIL spec_pred_pre: got %b need 1", pred); end
        pred_fire = 1'b1;
        @(negedge clk);
        pred_fire = 1'b0;
        n_tests++;
        if (global_history !== 4'b0001) begin n_fail++; $display("FAIL spec_fire_shift: got %b need 0001", global_history); end
        pred_fire = 1'b1;
        update = 1'b1; update_index = 4'd9; update_ctr = 2'd2; actual = 1'b0; update_history = 4'b0010;
        @(negedge clk);
        pred_fire = 1'b0; update = 1'b0;
        n_tests++;
        if (global_history !== 4'b0100) begin n_fail++; $display("FAIL spec_recover: got %b need 0100", global_history); end
        update = 1'b1; update_index = 4'd3; update_ctr = 2'd2; actual = 1'b1; update_history = 4'b1111;
        @(negedge clk);
        update = 1'b0;
        n_tests++;
        if (global_history !== 4'b0100) begin n_fail++; $display("FAIL spec_correct_hold: got %b need 0100", global_history); end
    endtask
`endif

    task automatic test_mid_sweep_reset();
        int c;
        exp_t e;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pc = 32'h3C;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests += 5;
        if (ready !== 1'b0)      begin n_fail++; $display("FAIL mid_rst_ready: got %b need 0", ready); end
        if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pred_valid: got %b need 0", pred_valid); end
        if (pred_index !== '0)   begin n_fail++; $display("FAIL mid_rst_pred_index: got %h need 0", pred_index); end
        if (pred_ctr !== '0)     begin n_fail++; $display("FAIL mid_rst_pred_ctr: got %h need 0", pred_ctr); end
        if (pred !== 1'b0)       begin n_fail++; $display("FAIL mid_rst_pred: got %b need 0", pred); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        c = 0;
        while (ready !== 1'b1 && c < 100) begin
            c++;
            @(negedge clk);
        end
        n_tests++;
        if (c != 16) begin n_fail++; $display("FAIL mid_rst_low_cycles: got %0d need 16", c); end
        pc = 32'({4'd5 ^ hist_m, 2'b00});
        sb_q.push_back('{idx: 4'd5, ctr: mem_m[5]});
        @(negedge clk);
        e = sb_q.pop_front();
        n_tests++;
        if (pred_ctr !== e.ctr) begin n_fail++; $display("FAIL mid_rst_reinit_ctr: got %h need %h", pred_ctr, e.ctr); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_counters();
        test_bypass();
`ifndef BP_SPEC_HISTORY_EN
        test_history();
`else
        test_spec_history();
`endif
        test_mid_sweep_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
